// File: rtl/send_arbiter_if.sv
// Handshake bundle between the requesters, the send arbiter and the multisend channel.
interface send_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_num;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic                busy;
    logic [31:0]         ms_num;
    logic                ms_enabled;
    logic                ms_done;

    modport slave (
        input  req, req_num, ms_done,
        output grant, done, err, busy, ms_num, ms_enabled
    );

    modport master (
        output req, req_num, ms_done,
        input  grant, done, err, busy, ms_num, ms_enabled
    );
endinterface

// File: rtl/send_arbiter.sv
// Round-robin arbiter sharing one multisend channel: latches the winner's value,
// sequences enable/done, then enforces an idle gap and an optional watchdog.
module send_arbiter #(
    parameter int N_REQ          = 4,
    parameter int LOAD_CYCLES    = 2,
    parameter int GAP_CYCLES     = 1200000,
    parameter int TIMEOUT_CYCLES = 24000000
) (
    input  logic           hwclk,
    input  logic           rst,
    send_arbiter_if.slave  sif
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FINISH, GAP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [31:0]      num_q, num_d;
    logic             en_q, en_d;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    jj;
    int               j;

    // Walk downward so the last hit, i.e. the one nearest ptr+1, wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        jj       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j  = (int'(ptr_q) + k) % N_REQ;
            jj = IW'(j);
            if (sif.req[jj]) begin
                pick_vld = 1'b1;
                pick_idx = jj;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            num_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            num_q   <= num_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        num_d   = num_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    num_d   = sif.req_num[32*pick_idx +: 32];
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == 32'(LOAD_CYCLES)) begin
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RUN: begin
                // A done arriving on the timeout cycle still counts as success.
                if (sif.ms_done) begin
                    done_d  = grant_q;
                    state_d = FINISH;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = grant_q;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            FINISH: begin
                en_d    = 1'b0;
                grant_d = '0;
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sif.grant      = grant_q;
    assign sif.done       = done_q;
    assign sif.err        = err_q;
    assign sif.busy       = (state_q != IDLE);
    assign sif.ms_num     = num_q;
    assign sif.ms_enabled = en_q;
endmodule

// File: tb/tb_send_arbiter.sv
// Scenario bench for send_arbiter with a behavioural multisend model and a grant scoreboard.
module tb_send_arbiter;
    localparam int N  = 4;
    localparam int LC = 2;
    localparam int GC = 4;
    localparam int TC = 50;

    typedef struct {
        int          idx;
        logic [31:0] num;
        bit          is_err;
    } exp_t;

    logic hwclk = 1'b0;
    logic rst   = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   md_delay = 10;
    int   mcnt  = 0;
    exp_t sb[$];
    exp_t cur;

    send_arbiter_if #(.N_REQ(N)) sif();

    send_arbiter #(
        .N_REQ(N), .LOAD_CYCLES(LC), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .hwclk(hwclk),
        .rst  (rst),
        .sif  (sif.slave)
    );

    always #5 hwclk = ~hwclk;

    // multisend: done rises md_delay cycles after enable, held until enable drops
    always @(posedge hwclk) begin
        if (!sif.ms_enabled) begin
            mcnt        <= 0;
            sif.ms_done <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (md_delay != 0 && mcnt + 1 >= md_delay) sif.ms_done <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic set_num(input int i, input logic [31:0] v);
        sif.req_num[32*i +: 32] = v;
    endtask

    task automatic wait_grant(input int bound, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge hwclk); cyc++;
            ok = (sif.grant != '0);
        end
    endtask

    task automatic wait_resp(input int bound, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge hwclk); cyc++;
            ok = ((sif.done | sif.err) != '0);
        end
    endtask

    task automatic wait_en(input int bound, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge hwclk); cyc++;
            ok = (sif.ms_enabled === 1'b1);
        end
    endtask

    task automatic wait_idle(input int bound, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge hwclk); cyc++;
            ok = (sif.busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sif.req = '0; sif.req_num = '0;
        tick(3);
        total++;
        if ({sif.grant, sif.done, sif.err} !== 12'b0) begin
            bad++; $display("FAIL reset_gde got=%b want=0", {sif.grant, sif.done, sif.err});
        end
        total++;
        if ({sif.busy, sif.ms_enabled} !== 2'b00) begin
            bad++; $display("FAIL reset_busy_en got=%b want=00", {sif.busy, sif.ms_enabled});
        end
        total++;
        if (sif.ms_num !== 32'd0) begin
            bad++; $display("FAIL reset_ms_num got=%0d want=0", sif.ms_num);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit ok;
        set_num(0, 32'd123456);
        sb.push_back('{0, 32'd123456, 1'b0});
        sif.req = 4'b0001;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || cyc != 1 || sif.grant !== oh(cur.idx)) begin
            bad++; $display("FAIL single_grant got=%b after %0d want=%b after 1", sif.grant, cyc, oh(cur.idx));
        end
        total++;
        if (sif.ms_num !== cur.num) begin
            bad++; $display("FAIL single_num got=%0d want=%0d", sif.ms_num, cur.num);
        end
        wait_en(20, cyc, ok);
        total++;
        if (!ok || cyc != LC + 1) begin
            bad++; $display("FAIL single_en_latency got=%0d want=%0d", cyc, LC + 1);
        end
        wait_resp(50, cyc, ok);
        total++;
        if (!ok || sif.done !== oh(cur.idx) || sif.err !== '0) begin
            bad++; $display("FAIL single_done got=%b/%b want=%b/0000", sif.done, sif.err, oh(cur.idx));
        end
        sif.req = '0;
        tick(1);
        total++;
        if (sif.done !== '0) begin
            bad++; $display("FAIL single_done_pulse got=%b want=0000", sif.done);
        end
        wait_idle(20, cyc, ok);
        total++;
        if (!ok || cyc + 1 != GC + 1) begin
            bad++; $display("FAIL single_busy_drop got=%0d want=%0d", cyc + 1, GC + 1);
        end
    endtask

    task automatic test_round_robin();
        int cyc; bit ok;
        int order[6] = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1; sif.req = '0; tick(2); rst = 1'b0;
        for (int i = 0; i < N; i++) set_num(i, 32'(1000 + i));
        for (int t = 0; t < 6; t++) sb.push_back('{order[t], 32'(1000 + order[t]), 1'b0});
        sif.req = 4'b1011;
        for (int t = 0; t < 6; t++) begin
            wait_grant(100, cyc, ok);
            cur = sb.pop_front();
            total++;
            if (!ok || sif.grant !== oh(cur.idx)) begin
                bad++; $display("FAIL rr_grant%0d got=%b want=%b", t, sif.grant, oh(cur.idx));
            end
            if (t > 0) begin
                total++;
                if (cyc - 1 < GC) begin
                    bad++; $display("FAIL rr_gap%0d got=%0d want>=%0d", t, cyc - 1, GC);
                end
            end
            total++;
            if (sif.ms_num !== cur.num) begin
                bad++; $display("FAIL rr_num%0d got=%0d want=%0d", t, sif.ms_num, cur.num);
            end
            wait_resp(100, cyc, ok);
            total++;
            if (!ok || sif.done !== oh(cur.idx) || sif.err !== '0) begin
                bad++; $display("FAIL rr_done%0d got=%b/%b want=%b/0000", t, sif.done, sif.err, oh(cur.idx));
            end
            if (t == 5) sif.req = '0;
        end
        wait_idle(20, cyc, ok);
    endtask

    task automatic test_simultaneous();
        int cyc; bit ok;
        md_delay = TC - 1;
        set_num(2, 32'd77);
        sb.push_back('{2, 32'd77, 1'b0});
        sif.req = 4'b0100;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || sif.grant !== oh(cur.idx)) begin
            bad++; $display("FAIL simul_grant got=%b want=%b", sif.grant, oh(cur.idx));
        end
        wait_en(20, cyc, ok);
        wait_resp(100, cyc, ok);
        total++;
        if (!ok || cyc != TC || sif.done !== oh(cur.idx) || sif.err !== '0) begin
            bad++; $display("FAIL simul_done got=%b/%b at %0d want=%b/0000 at %0d", sif.done, sif.err, cyc, oh(cur.idx), TC);
        end
        sif.req = '0;
        wait_idle(20, cyc, ok);
        md_delay = 10;
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        md_delay = 0;
        set_num(0, 32'd11);
        set_num(1, 32'd22);
        sb.push_back('{0, 32'd11, 1'b1});
        sb.push_back('{1, 32'd22, 1'b0});
        sif.req = 4'b0011;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || sif.grant !== oh(cur.idx)) begin
            bad++; $display("FAIL to_grant got=%b want=%b", sif.grant, oh(cur.idx));
        end
        wait_en(20, cyc, ok);
        wait_resp(100, cyc, ok);
        total++;
        if (!ok || cyc != TC || sif.err !== oh(cur.idx) || sif.done !== '0) begin
            bad++; $display("FAIL to_err got=%b/%b at %0d want=0000/%b at %0d", sif.done, sif.err, cyc, oh(cur.idx), TC);
        end
        sif.req = 4'b0010;
        md_delay = 10;
        tick(1);
        total++;
        if (sif.ms_enabled !== 1'b0) begin
            bad++; $display("FAIL to_en_drop got=%b want=0", sif.ms_enabled);
        end
        wait_grant(50, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || sif.grant !== oh(cur.idx) || sif.ms_num !== cur.num) begin
            bad++; $display("FAIL to_next_grant got=%b/%0d want=%b/%0d", sif.grant, sif.ms_num, oh(cur.idx), cur.num);
        end
        wait_resp(100, cyc, ok);
        total++;
        if (!ok || sif.done !== oh(cur.idx) || sif.err !== '0) begin
            bad++; $display("FAIL to_next_done got=%b/%b want=%b/0000", sif.done, sif.err, oh(cur.idx));
        end
        sif.req = '0;
        wait_idle(20, cyc, ok);
    endtask

    task automatic test_mid_change();
        int cyc; bit ok;
        set_num(0, 32'd555);
        sb.push_back('{0, 32'd555, 1'b0});
        sif.req = 4'b0001;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || sif.grant !== oh(cur.idx)) begin
            bad++; $display("FAIL mid_grant got=%b want=%b", sif.grant, oh(cur.idx));
        end
        wait_en(20, cyc, ok);
        set_num(0, 32'd999);
        sif.req = '0;
        tick(1);
        total++;
        if (sif.ms_num !== cur.num) begin
            bad++; $display("FAIL mid_num got=%0d want=%0d", sif.ms_num, cur.num);
        end
        wait_resp(50, cyc, ok);
        total++;
        if (!ok || sif.done !== oh(cur.idx) || sif.err !== '0) begin
            bad++; $display("FAIL mid_done got=%b/%b want=%b/0000", sif.done, sif.err, oh(cur.idx));
        end
        wait_idle(20, cyc, ok);
    endtask

    task automatic test_reset_run();
        int cyc; bit ok;
        set_num(1, 32'd42);
        sif.req = 4'b0010;
        wait_grant(10, cyc, ok);
        wait_en(20, cyc, ok);
        tick(3);
        rst = 1'b1; sif.req = '0;
        tick(1);
        total++;
        if ({sif.grant, sif.done, sif.err, sif.busy, sif.ms_enabled} !== 14'b0 || sif.ms_num !== 32'd0) begin
            bad++; $display("FAIL rstrun_outputs got=%b num=%0d want=0", {sif.grant, sif.done, sif.err, sif.busy, sif.ms_enabled}, sif.ms_num);
        end
        rst = 1'b0;
        set_num(2, 32'd88);
        sb.push_back('{2, 32'd88, 1'b0});
        sif.req = 4'b0100;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || cyc != 1 || sif.grant !== oh(cur.idx)) begin
            bad++; $display("FAIL rstrun_grant got=%b after %0d want=%b after 1", sif.grant, cyc, oh(cur.idx));
        end
        wait_resp(50, cyc, ok);
        sif.req = '0;
        wait_idle(20, cyc, ok);
        // pointer must restart at N-1: with 1 and 3 pending, 1 goes first
        rst = 1'b1; tick(1); rst = 1'b0;
        set_num(1, 32'd5);
        set_num(3, 32'd6);
        sb.push_back('{1, 32'd5, 1'b0});
        sif.req = 4'b1010;
        wait_grant(10, cyc, ok);
        cur = sb.pop_front();
        total++;
        if (!ok || sif.grant !== oh(cur.idx) || sif.ms_num !== cur.num) begin
            bad++; $display("FAIL rstrun_ptr got=%b/%0d want=%b/%0d", sif.grant, sif.ms_num, oh(cur.idx), cur.num);
        end
        sif.req = '0;
        wait_resp(50, cyc, ok);
        wait_idle(20, cyc, ok);
    endtask

    initial begin
        sif.req     = '0;
        sif.req_num = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_simultaneous();
        test_timeout();
        test_mid_change();
        test_reset_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
